gray_to_binary_serial: RTL and testbench



---
 rtl/gray_to_binary_serial_pkg.sv | 17 +
 rtl/gray_to_binary_serial_if.sv | 24 ++
 rtl/gray_to_binary_serial_step_check.sv | 31 +++
 rtl/gray_to_binary_serial.sv | 70 +++++++
 tb/tb_gray_to_binary_serial.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gray_to_binary_serial_pkg.sv
// gray_pkg: shared state encoding and helpers for the serial Gray-to-binary decoder
package gray_pkg;

    localparam int GRAY_MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // More than one bit set exactly when clearing the lowest set bit leaves a nonzero value
    function automatic logic gray_popcount_gt1(input logic [GRAY_MAX_WIDTH-1:0] x);
        return (x != '0) && ((x & (x - 32'd1)) != '0);
    endfunction

endpackage

// File: rtl/gray_to_binary_serial_if.sv
// gray_to_binary_serial_if: input/output valid-ready handshakes and busy status of the decoder
interface gray_to_binary_serial_if #(
    parameter int WIDTH = 4
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] gray_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] bin_out;
    logic             busy;

    modport master (
        output in_valid, gray_in, out_ready,
        input  in_ready, out_valid, bin_out, busy
    );

    modport slave (
        input  in_valid, gray_in, out_ready,
        output in_ready, out_valid, bin_out, busy
    );

endinterface

// File: rtl/gray_to_binary_serial_step_check.sv
// gray_step_check: flags accepted Gray words that differ from the previous one in more than one bit
module gray_step_check
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             accept,
    input  logic [WIDTH-1:0] gray_in,
    output logic             step_err
);

    logic [WIDTH-1:0] prev;
    logic             seen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev     <= '0;
            seen     <= 1'b0;
            step_err <= 1'b0;
        end else begin
            step_err <= accept && seen && gray_popcount_gt1(GRAY_MAX_WIDTH'(gray_in ^ prev));
            if (accept) begin
                prev <= gray_in;
                seen <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/gray_to_binary_serial.sv
// gray_to_binary_serial: decodes one Gray word MSB-first, one bit per clock.
// Define GRAY_STEP_CHECK_EN to add the step_err output for multi-bit Gray steps.
module gray_to_binary_serial
    import gray_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int IDXW = $clog2(WIDTH)
) (
    input  logic clk,
    input  logic rst_n,
`ifdef GRAY_STEP_CHECK_EN
    output logic step_err,
`endif
    gray_to_binary_serial_if.slave bus
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] g_reg, work_reg, work_up, work_nxt, bin_reg;
    logic [IDXW-1:0]  idx;
    logic             accept, last;

    assign accept  = (state == IDLE) && bus.in_valid;
    assign last    = idx == '0;
    // work_up[idx] is the already-resolved bit above idx, and 0 above the MSB
    assign work_up = {1'b0, work_reg[WIDTH-1:1]};

    always_comb begin
        work_nxt      = work_reg;
        work_nxt[idx] = work_up[idx] ^ g_reg[idx];
        state_nxt     = state == IDLE ? (accept ? CONV : IDLE)
                      : state == CONV ? (last ? DONE : CONV)
                      : (bus.out_ready ? IDLE : DONE);
        bus.in_ready  = state == IDLE;
        bus.busy      = state != IDLE;
        bus.out_valid = state == DONE;
        bus.bin_out   = bin_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            g_reg    <= '0;
            work_reg <= '0;
            idx      <= '0;
            bin_reg  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                g_reg <= bus.gray_in;
                idx   <= IDXW'(WIDTH - 1);
            end
            if (state == CONV) begin
                work_reg <= work_nxt;
                idx      <= idx - IDXW'(1);
                if (last) bin_reg <= work_nxt;
            end
        end
    end

`ifdef GRAY_STEP_CHECK_EN
    gray_step_check #(.WIDTH(WIDTH)) u_step_check (
        .clk      (clk),
        .rst_n    (rst_n),
        .accept   (accept),
        .gray_in  (bus.gray_in),
        .step_err (step_err)
    );
`endif

endmodule

// File: tb/tb_gray_to_binary_serial.sv
// tb_gray_to_binary_serial: directed-vector bench for the WIDTH=4 serial Gray-to-binary decoder
module tb_gray_to_binary_serial;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    gray_to_binary_serial_if #(.WIDTH(W)) bus ();

`ifdef GRAY_STEP_CHECK_EN
    logic step_err;
`endif

    gray_to_binary_serial #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef GRAY_STEP_CHECK_EN
        .step_err (step_err),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Drives one word from IDLE with out_ready high; returns result and edges from accept to out_valid
    task automatic do_word(input logic [W-1:0] g, output logic [W-1:0] res, output int lat);
        bus.gray_in  = g;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus.bin_out;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.gray_in = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.bin_out !== 4'b0000) begin
            failures++;
            $display("FAIL reset: in_ready=%b out_valid=%b busy=%b bin_out=%b, want 1 0 0 0000",
                     bus.in_ready, bus.out_valid, bus.busy, bus.bin_out);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int busy_cnt = 0;
        int lat = 0;
        bus.out_ready = 1'b1;
        bus.gray_in = 4'b1000;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.gray_in = 4'b0101;
        while (!bus.out_valid && lat < 20) begin
            if (bus.busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        if (bus.busy) busy_cnt++;
        checks++;
        if (lat !== W) begin
            failures++;
            $display("FAIL basic_latency: got %0d edges, want %0d", lat, W);
        end
        checks++;
        if (bus.bin_out !== 4'b1111) begin
            failures++;
            $display("FAIL basic_bin_out: got %b, want 1111", bus.bin_out);
        end
        @(posedge clk); #1;
        checks++;
        if (busy_cnt !== 5 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy: got %0d cycles (busy now %b), want 5 (0)", busy_cnt, bus.busy);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_return_idle: out_valid=%b in_ready=%b, want 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_b [2] = '{4'b0010, 4'b1011};
        int sec = 0;
        int got = 0;
        bus.out_ready = 1'b1;
        bus.gray_in = 4'b0011;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.gray_in = 4'b1110;
        for (int c = 1; c <= 30 && got < 2; c++) begin
            @(posedge clk); #1;
            if (c == sec) bus.in_valid = 1'b0;
            if (sec == 0 && bus.in_ready) sec = c + 1;
            if (bus.out_valid) begin
                checks++;
                if (bus.bin_out !== exp_b[got]) begin
                    failures++;
                    $display("FAIL b2b_word%0d: got %b, want %b", got, bus.bin_out, exp_b[got]);
                end
                got++;
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (sec !== W + 2) begin
            failures++;
            $display("FAIL b2b_interval: second accept %0d cycles after first, want %0d", sec, W + 2);
        end
        checks++;
        if (got !== 2) begin
            failures++;
            $display("FAIL b2b_count: got %0d results, want 2", got);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        int lat = 0;
        bus.out_ready = 1'b0;
        bus.gray_in = 4'b0110;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.bin_out !== 4'b0100 || bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold%0d: out_valid=%b bin_out=%b in_ready=%b, want 1 0100 0",
                         i, bus.out_valid, bus.bin_out, bus.in_ready);
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.bin_out !== 4'b0100) begin
            failures++;
            $display("FAIL stall_release: out_valid=%b in_ready=%b bin_out=%b, want 0 1 0100",
                     bus.out_valid, bus.in_ready, bus.bin_out);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] res;
        int lat;
        int seen_valid = 0;
        bus.out_ready = 1'b1;
        bus.gray_in = 4'b1111;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.bin_out !== 4'b0000) begin
            failures++;
            $display("FAIL midreset_async: in_ready=%b out_valid=%b busy=%b bin_out=%b, want 1 0 0 0000",
                     bus.in_ready, bus.out_valid, bus.busy, bus.bin_out);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen_valid++;
        end
        checks++;
        if (seen_valid !== 0) begin
            failures++;
            $display("FAIL midreset_no_valid: out_valid seen %0d cycles, want 0", seen_valid);
        end
        do_word(4'b0001, res, lat);
        checks++;
        if (res !== 4'b0001 || lat !== W) begin
            failures++;
            $display("FAIL midreset_next: bin_out=%b latency=%0d, want 0001 %0d", res, lat, W);
        end
    endtask

    task automatic test_sweep();
        logic [W-1:0] g, exp_b, res;
        int lat;
        for (int v = 0; v < 16; v++) begin
            g = W'(v);
            for (int i = 0; i < W; i++) exp_b[i] = ^(g >> i);
            do_word(g, res, lat);
            checks++;
            if (res !== exp_b || lat !== W) begin
                failures++;
                $display("FAIL sweep_g%b: bin_out=%b latency=%0d, want %b %0d", g, res, lat, exp_b, W);
            end
        end
    endtask

`ifdef GRAY_STEP_CHECK_EN
    task automatic test_step_check();
        logic [W-1:0] words [4] = '{4'b0000, 4'b0001, 4'b0011, 4'b0000};
        logic         exp_e [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int lat;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.gray_in = words[i];
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            checks++;
            if (step_err !== exp_e[i]) begin
                failures++;
                $display("FAIL step_err_word%0d: got %b, want %b", i, step_err, exp_e[i]);
            end
            @(posedge clk); #1;
            checks++;
            if (step_err !== 1'b0) begin
                failures++;
                $display("FAIL step_err_pulse%0d: got %b, want 0", i, step_err);
            end
            lat = 0;
            while (!bus.out_valid && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            @(posedge clk); #1;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_sweep();
`ifdef GRAY_STEP_CHECK_EN
        test_step_check();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
